// File: rtl/cpu_controller_if.sv
// Controller <-> datapath bundle for the multicycle CPU.
// master = controller side, slave = datapath side.
interface cpu_controller_if #(
   parameter int WIDTH            = 16,
   parameter int ALU_CONT_BITS    = 6,
   parameter int OP_CODE_BITS     = 4,
   parameter int EXT_OP_CODE_BITS = 4,
   parameter int REG_BITS         = 4
);
   logic [OP_CODE_BITS-1:0]     op_code;
   logic [EXT_OP_CODE_BITS-1:0] ext_op_code;
   logic [REG_BITS-1:0]         A_index;
   logic [WIDTH-1:0]            psr_flags;
   logic                        reg_write;
   logic                        alu_A_src;
   logic                        alu_B_src;
   logic                        pc_en;
   logic                        loading;
   logic                        storing;
   logic                        instruction_en;
   logic                        mem_write;
   logic [1:0]                  pc_src;
   logic [1:0]                  reg_write_src;
   logic [ALU_CONT_BITS-1:0]    alu_cont;

   modport master (
      input  op_code, ext_op_code, A_index, psr_flags,
      output reg_write, alu_A_src, alu_B_src, pc_en, loading, storing,
             instruction_en, mem_write, pc_src, reg_write_src, alu_cont
   );

   modport slave (
      output op_code, ext_op_code, A_index, psr_flags,
      input  reg_write, alu_A_src, alu_B_src, pc_en, loading, storing,
             instruction_en, mem_write, pc_src, reg_write_src, alu_cont
   );
endinterface

// File: rtl/cpu_controller.sv
// Multicycle control FSM: FETCH -> DECODE -> EXEC/MEM/JUMP/BRANCH -> FETCH.
// Outputs are registered (computed for the state being entered), except the
// taken-dependent pc_src in JUMP/BRANCH, which follows live psr_flags.
// Optional retired-instruction counter: define CPU_CONTROLLER_PERF_CNT_EN.
module cpu_controller #(
   parameter int WIDTH            = 16,
   parameter int ALU_CONT_BITS    = 6,
   parameter int OP_CODE_BITS     = 4,
   parameter int EXT_OP_CODE_BITS = 4,
   parameter int REG_BITS         = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   cpu_controller_if.master      bus
`ifdef CPU_CONTROLLER_PERF_CNT_EN
   ,
   output logic [WIDTH-1:0]      instr_count
`endif
);

   typedef enum logic [3:0] {
      S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM_RD,
      S_LD_WB, S_MEM_WR, S_JUMP, S_BRANCH
   } state_t;

   typedef struct packed {
      logic                     reg_write;
      logic                     alu_A_src;
      logic                     alu_B_src;
      logic                     pc_en;
      logic                     loading;
      logic                     storing;
      logic                     instruction_en;
      logic                     mem_write;
      logic [1:0]               pc_src;
      logic [1:0]               reg_write_src;
      logic [ALU_CONT_BITS-1:0] alu_cont;
   } ctrl_t;

   localparam logic [ALU_CONT_BITS-1:0] ALU_ADD = 6'b000101;
   localparam ctrl_t C_IDLE = '{reg_write: 1'b0, alu_A_src: 1'b1, alu_B_src: 1'b0,
                                pc_en: 1'b0, loading: 1'b0, storing: 1'b0,
                                instruction_en: 1'b0, mem_write: 1'b0,
                                pc_src: 2'd2, reg_write_src: 2'd0, alu_cont: ALU_ADD};

   state_t r_state;
   ctrl_t  r_ctrl;
   logic   r_jcond;

   logic [OP_CODE_BITS-1:0]     w_op;
   logic [EXT_OP_CODE_BITS-1:0] w_ext;
   logic [REG_BITS-1:0]         w_cond;
   logic w_is_r, w_is_imm, w_is_load, w_is_stor, w_is_jal, w_is_jcond, w_is_bcond;
   logic w_taken;
   logic [1:0] w_pc_src;
   logic w_unused_flags;

   assign w_op   = bus.op_code;
   assign w_ext  = bus.ext_op_code;
   assign w_cond = bus.A_index;
   assign w_unused_flags = ^{bus.psr_flags[WIDTH-1:8], bus.psr_flags[4:3], bus.psr_flags[1]};

   // Instruction class decode from the latched instruction fields
   always_comb begin
      w_is_r     = (w_op == 4'b0000);
      w_is_imm   = (w_op inside {4'b0101, 4'b1001, 4'b1011, 4'b0001,
                                 4'b0010, 4'b0011, 4'b1101});
      w_is_load  = (w_op == 4'b0100) && (w_ext == 4'b0000);
      w_is_stor  = (w_op == 4'b0100) && (w_ext == 4'b0100);
      w_is_jal   = (w_op == 4'b0100) && (w_ext == 4'b1000);
      w_is_jcond = (w_op == 4'b0100) && (w_ext == 4'b1100);
      w_is_bcond = (w_op == 4'b1100);
   end

   // Condition evaluation: C=bit0, L=bit2, Z=bit6
   always_comb begin
      w_taken = 1'b0;
      case (w_cond)
         4'b0000: w_taken =  bus.psr_flags[6];
         4'b0001: w_taken = ~bus.psr_flags[6];
         4'b0010: w_taken =  bus.psr_flags[0];
         4'b0011: w_taken = ~bus.psr_flags[0];
         4'b1100: w_taken =  bus.psr_flags[2];
         4'b1101: w_taken = ~bus.psr_flags[2];
         4'b1110: w_taken =  1'b1;
         default: w_taken =  1'b0;
      endcase
   end

   // pc_src: conditional transfers resolve against the current flags
   always_comb begin
      w_pc_src = r_ctrl.pc_src;
      if (r_state == S_JUMP && r_jcond) w_pc_src = w_taken ? 2'd1 : 2'd2;
      else if (r_state == S_BRANCH)     w_pc_src = w_taken ? 2'd0 : 2'd2;
   end

   // State sequencing with registered outputs for the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_START;
         r_ctrl  <= C_IDLE;
         r_jcond <= 1'b0;
      end else begin
         r_ctrl <= C_IDLE;
         case (r_state)
            S_START: begin
               r_state <= S_FETCH;
               r_ctrl.instruction_en <= 1'b1;
            end
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               r_jcond <= w_is_jcond;
               if (w_is_load) begin
                  r_state <= S_MEM_RD;
                  r_ctrl.loading <= 1'b1;
               end else if (w_is_stor) begin
                  r_state <= S_MEM_WR;
                  r_ctrl.storing   <= 1'b1;
                  r_ctrl.mem_write <= 1'b1;
                  r_ctrl.pc_en     <= 1'b1;
               end else if (w_is_jal || w_is_jcond) begin
                  r_state <= S_JUMP;
                  r_ctrl.pc_en <= 1'b1;
                  if (w_is_jal) begin
                     r_ctrl.reg_write     <= 1'b1;
                     r_ctrl.reg_write_src <= 2'd2;
                     r_ctrl.pc_src        <= 2'd1;
                  end
               end else if (w_is_bcond) begin
                  r_state <= S_BRANCH;
                  r_ctrl.alu_A_src <= 1'b0;
                  r_ctrl.alu_B_src <= 1'b1;
                  r_ctrl.pc_en     <= 1'b1;
               end else begin
                  // R-type, immediate, or unrecognised encoding (NOP)
                  r_state <= S_EXEC;
                  r_ctrl.pc_en <= 1'b1;
                  if (w_is_r) begin
                     r_ctrl.alu_cont  <= {2'b00, w_ext};
                     r_ctrl.reg_write <= (w_ext != 4'b1011);
                  end else if (w_is_imm) begin
                     r_ctrl.alu_B_src <= 1'b1;
                     r_ctrl.alu_cont  <= {2'b01, w_op};
                     r_ctrl.reg_write <= (w_op != 4'b1011);
                  end
               end
            end
            S_MEM_RD: begin
               r_state <= S_LD_WB;
               r_ctrl.loading       <= 1'b1;
               r_ctrl.reg_write     <= 1'b1;
               r_ctrl.reg_write_src <= 2'd1;
               r_ctrl.pc_en         <= 1'b1;
            end
            S_EXEC, S_LD_WB, S_MEM_WR, S_JUMP, S_BRANCH: begin
               r_state <= S_FETCH;
               r_ctrl.instruction_en <= 1'b1;
            end
            default: r_state <= S_START;
         endcase
      end
   end

`ifdef CPU_CONTROLLER_PERF_CNT_EN
   logic [WIDTH-1:0] r_instr_count;

   // Count retirements: every final state returns to FETCH on the next edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_instr_count <= '0;
      else if (r_state inside {S_EXEC, S_LD_WB, S_MEM_WR, S_JUMP, S_BRANCH})
         r_instr_count <= r_instr_count + 1'b1;
   end

   assign instr_count = r_instr_count;
`endif

   assign bus.reg_write      = r_ctrl.reg_write;
   assign bus.alu_A_src      = r_ctrl.alu_A_src;
   assign bus.alu_B_src      = r_ctrl.alu_B_src;
   assign bus.pc_en          = r_ctrl.pc_en;
   assign bus.loading        = r_ctrl.loading;
   assign bus.storing        = r_ctrl.storing;
   assign bus.instruction_en = r_ctrl.instruction_en;
   assign bus.mem_write      = r_ctrl.mem_write;
   assign bus.pc_src         = w_pc_src;
   assign bus.reg_write_src  = r_ctrl.reg_write_src;
   assign bus.alu_cont       = r_ctrl.alu_cont;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: table of hand-computed instruction results,
// random instruction stream against a per-instruction reference model,
// and reset sequences (power-on and mid-STOR).
module tb_cpu_controller;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cpu_controller_if bus ();
`ifdef CPU_CONTROLLER_PERF_CNT_EN
   logic [15:0] instr_count;
`endif

   cpu_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef CPU_CONTROLLER_PERF_CNT_EN
      , .instr_count (instr_count)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;
   int model_cnt = 0;
   logic [17:0] exp_seq [0:3];
   int exp_len;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  ext;
      logic [3:0]  a;
      logic [15:0] psr;
      logic [17:0] fin;
      string       name;
   } vec_t;
   vec_t tbl [0:15];

   // Control word: {rw,aA,aB,pce,ld,st,ie,mw,pc_src,rw_src,alu_cont}
   function automatic logic [17:0] mk(input bit rw, input bit aA, input bit aB,
                                      input bit pce, input bit ld, input bit st,
                                      input bit ie, input bit mw, input logic [1:0] pcs,
                                      input logic [1:0] rws, input logic [5:0] alu);
      return {rw, aA, aB, pce, ld, st, ie, mw, pcs, rws, alu};
   endfunction

   function automatic logic [17:0] dut_word();
      return {bus.reg_write, bus.alu_A_src, bus.alu_B_src, bus.pc_en, bus.loading,
              bus.storing, bus.instruction_en, bus.mem_write, bus.pc_src,
              bus.reg_write_src, bus.alu_cont};
   endfunction

   function automatic bit cond_taken(input logic [3:0] c, input logic [15:0] f);
      bit z, cy, l;
      z = f[6]; cy = f[0]; l = f[2];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd12: return l;
         4'd13: return !l;
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Expected control word for each cycle of one instruction, FETCH first
   task automatic build(input logic [3:0] op, input logic [3:0] ext,
                        input logic [3:0] a, input logic [15:0] psr);
      bit tk;
      tk = cond_taken(a, psr);
      exp_seq[0] = mk(0,1,0,0,0,0,1,0,2'd2,2'd0,6'd5);
      exp_seq[1] = mk(0,1,0,0,0,0,0,0,2'd2,2'd0,6'd5);
      exp_seq[3] = '0;
      exp_len = 3;
      if (op == 4'd4 && ext == 4'd0) begin
         exp_len = 4;
         exp_seq[2] = mk(0,1,0,0,1,0,0,0,2'd2,2'd0,6'd5);
         exp_seq[3] = mk(1,1,0,1,1,0,0,0,2'd2,2'd1,6'd5);
      end else if (op == 4'd4 && ext == 4'd4)
         exp_seq[2] = mk(0,1,0,1,0,1,0,1,2'd2,2'd0,6'd5);
      else if (op == 4'd4 && ext == 4'd8)
         exp_seq[2] = mk(1,1,0,1,0,0,0,0,2'd1,2'd2,6'd5);
      else if (op == 4'd4 && ext == 4'd12)
         exp_seq[2] = mk(0,1,0,1,0,0,0,0,(tk ? 2'd1 : 2'd2),2'd0,6'd5);
      else if (op == 4'd12)
         exp_seq[2] = mk(0,0,1,1,0,0,0,0,(tk ? 2'd0 : 2'd2),2'd0,6'd5);
      else if (op == 4'd0)
         exp_seq[2] = mk(ext != 4'd11,1,0,1,0,0,0,0,2'd2,2'd0,{2'b00, ext});
      else if (op inside {4'd5, 4'd9, 4'd11, 4'd1, 4'd2, 4'd3, 4'd13})
         exp_seq[2] = mk(op != 4'd11,1,1,1,0,0,0,0,2'd2,2'd0,{2'b01, op});
      else
         exp_seq[2] = mk(0,1,0,1,0,0,0,0,2'd2,2'd0,6'd5);
   endtask

   task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_cnt(input string name);
`ifdef CPU_CONTROLLER_PERF_CNT_EN
      chk(name, {2'b00, instr_count}, 18'(model_cnt % 65536));
`else
      if (name.len() == 0) $display("empty name");
`endif
   endtask

   // Called at a negedge while the DUT is in FETCH; returns at the next FETCH
   task automatic run_instr(input logic [3:0] op, input logic [3:0] ext,
                            input logic [3:0] a, input logic [15:0] psr,
                            input string name, input bit use_tbl, input logic [17:0] fin);
      bus.op_code = op; bus.ext_op_code = ext; bus.A_index = a; bus.psr_flags = psr;
      build(op, ext, a, psr);
      chk({name, "_fetch"}, dut_word(), exp_seq[0]);
      chk_cnt({name, "_cnt"});
      for (int k = 1; k < exp_len; k++) begin
         @(negedge clk);
         chk($sformatf("%s_c%0d", name, k), dut_word(), exp_seq[k]);
         if (use_tbl && k == exp_len - 1) chk({name, "_tbl"}, dut_word(), fin);
      end
      @(negedge clk);
      model_cnt++;
   endtask

   // Hold reset for n cycles, release just after a rising edge, land in FETCH
   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) @(negedge clk);
      chk("rst_idle", dut_word(), mk(0,1,0,0,0,0,0,0,2'd2,2'd0,6'd5));
      model_cnt = 0;
      chk_cnt("rst_cnt");
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_start", dut_word(), mk(0,1,0,0,0,0,0,0,2'd2,2'd0,6'd5));
      @(negedge clk);
      chk("rst_fetch", dut_word(), mk(0,1,0,0,0,0,1,0,2'd2,2'd0,6'd5));
   endtask

   initial begin
      logic [3:0] op, ext, a;
      tbl[0]  = '{4'h5, 4'h0, 4'h0, 16'h0000, mk(1,1,1,1,0,0,0,0,2'd2,2'd0,6'b010101), "addi"};
      tbl[1]  = '{4'h0, 4'h5, 4'h3, 16'h0000, mk(1,1,0,1,0,0,0,0,2'd2,2'd0,6'b000101), "add"};
      tbl[2]  = '{4'h0, 4'hB, 4'h3, 16'h0000, mk(0,1,0,1,0,0,0,0,2'd2,2'd0,6'b001011), "cmp"};
      tbl[3]  = '{4'hB, 4'h2, 4'h1, 16'h0000, mk(0,1,1,1,0,0,0,0,2'd2,2'd0,6'b011011), "cmpi"};
      tbl[4]  = '{4'h4, 4'h0, 4'h2, 16'h0000, mk(1,1,0,1,1,0,0,0,2'd2,2'd1,6'b000101), "load"};
      tbl[5]  = '{4'h4, 4'h4, 4'h2, 16'h0000, mk(0,1,0,1,0,1,0,1,2'd2,2'd0,6'b000101), "stor"};
      tbl[6]  = '{4'h4, 4'h8, 4'h2, 16'h0000, mk(1,1,0,1,0,0,0,0,2'd1,2'd2,6'b000101), "jal"};
      tbl[7]  = '{4'h4, 4'hC, 4'hF, 16'hFFFF, mk(0,1,0,1,0,0,0,0,2'd2,2'd0,6'b000101), "jc_1111"};
      tbl[8]  = '{4'h4, 4'hC, 4'hE, 16'h0000, mk(0,1,0,1,0,0,0,0,2'd1,2'd0,6'b000101), "jc_uc"};
      tbl[9]  = '{4'hC, 4'h0, 4'h0, 16'h0040, mk(0,0,1,1,0,0,0,0,2'd0,2'd0,6'b000101), "beq_t"};
      tbl[10] = '{4'hC, 4'h0, 4'h0, 16'h0000, mk(0,0,1,1,0,0,0,0,2'd2,2'd0,6'b000101), "beq_nt"};
      tbl[11] = '{4'h7, 4'h0, 4'h0, 16'h0000, mk(0,1,0,1,0,0,0,0,2'd2,2'd0,6'b000101), "nop"};
      tbl[12] = '{4'hC, 4'h3, 4'hC, 16'h0004, mk(0,0,1,1,0,0,0,0,2'd0,2'd0,6'b000101), "blt_t"};
      tbl[13] = '{4'hD, 4'h1, 4'h5, 16'h0000, mk(1,1,1,1,0,0,0,0,2'd2,2'd0,6'b011101), "movi"};
      tbl[14] = '{4'h4, 4'hC, 4'h1, 16'h0040, mk(0,1,0,1,0,0,0,0,2'd2,2'd0,6'b000101), "jc_ne_nt"};
      tbl[15] = '{4'h4, 4'h1, 4'h0, 16'h0000, mk(0,1,0,1,0,0,0,0,2'd2,2'd0,6'b000101), "op4_nop"};

      bus.op_code = '0; bus.ext_op_code = '0; bus.A_index = '0; bus.psr_flags = '0;
      do_reset(3);

      for (int i = 0; i < 16; i++)
         run_instr(tbl[i].op, tbl[i].ext, tbl[i].a, tbl[i].psr, tbl[i].name, 1'b1, tbl[i].fin);

      // Reset asserted in MEM_WR: strobe must drop without waiting for a clock
      bus.op_code = 4'h4; bus.ext_op_code = 4'h4;
      @(negedge clk); @(negedge clk);
      chk("memwr_hi", {17'd0, bus.mem_write}, 18'd1);
      #2 reset = 1'b0;
      #1 chk("memwr_async", {17'd0, bus.mem_write}, 18'd0);
      chk("memwr_idle", dut_word(), mk(0,1,0,0,0,0,0,0,2'd2,2'd0,6'd5));
      do_reset(2);

      // Random instruction stream
      for (int i = 0; i < 200; i++) begin
         op  = 4'($urandom_range(0, 15));
         ext = 4'($urandom_range(0, 15));
         a   = 4'($urandom_range(0, 15));
         if (op == 4'd4 && $urandom_range(0, 3) != 0) ext = 4'($urandom_range(0, 3) * 4);
         if ($urandom_range(0, 1) == 1) a = 4'($urandom_range(12, 14));
         run_instr(op, ext, a, 16'($urandom), $sformatf("rnd%0d", i), 1'b0, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
